sensor_sample_fifo: RTL

Synchronous first-word-fall-through FIFO between a sensor acquisition FSM and the UART command FSM. Buffers sensor bytes on a valid/ready write port and exposes the head entry on the `valid_to_extract` / `extracted` read interface the UART FSM consumes. Also provides a flush input driven by the UART FSM's per-sensor reset, plus occupancy and sticky error flags for debug readback.

---
 rtl/sensor_sample_fifo_if.sv | 43 ++++
 rtl/sensor_sample_fifo.sv | 84 ++++++++
 2 files changed

// File: rtl/sensor_sample_fifo_if.sv
// Handshake bundle between the sensor FSM, the sample FIFO and the UART FSM.
// Signal names keep the FIFO-side i_/o_ view so both ends read the same.
interface sensor_sample_fifo_if #(
    parameter int DATA_DEPTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_DEPTH-1:0] i_wr_data;
    logic                  i_wr_valid;
    logic                  o_wr_ready;
    logic [DATA_DEPTH-1:0] o_data_out;
    logic                  o_data_out_valid_to_extract;
    logic                  i_data_out_extracted;
    logic                  i_flush;
    logic [ADDR_WIDTH:0]   o_count;
    logic                  o_overflow;
    logic                  o_underflow;

    modport master (
        output i_wr_data,
        output i_wr_valid,
        output i_data_out_extracted,
        output i_flush,
        input  o_wr_ready,
        input  o_data_out,
        input  o_data_out_valid_to_extract,
        input  o_count,
        input  o_overflow,
        input  o_underflow
    );

    modport slave (
        input  i_wr_data,
        input  i_wr_valid,
        input  i_data_out_extracted,
        input  i_flush,
        output o_wr_ready,
        output o_data_out,
        output o_data_out_valid_to_extract,
        output o_count,
        output o_overflow,
        output o_underflow
    );
endinterface

// File: rtl/sensor_sample_fifo.sv
// First-word-fall-through sample FIFO between sensor and UART FSMs.
// All outputs come from registers; flush outranks write and pop.
module sensor_sample_fifo #(
    parameter int DATA_DEPTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    sensor_sample_fifo_if.slave     bus_if
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_DEPTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic full, empty, wr_en, rd_en;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign wr_en = bus_if.i_wr_valid && !full && !bus_if.i_flush;
    assign rd_en = bus_if.i_data_out_extracted && !empty && !bus_if.i_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (bus_if.i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_en)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en)
                rd_ptr_d = rd_ptr_q + 1'b1;
            if (wr_en && !rd_en)
                count_d = count_q + 1'b1;
            else if (rd_en && !wr_en)
                count_d = count_q - 1'b1;
            // A pop in the same cycle does not rescue a write seen while full.
            if (bus_if.i_wr_valid && full)
                ovf_d = 1'b1;
            if (bus_if.i_data_out_extracted && empty)
                udf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= bus_if.i_wr_data;
    end

    assign bus_if.o_wr_ready                  = !full;
    assign bus_if.o_data_out_valid_to_extract = !empty;
    assign bus_if.o_data_out  = empty ? '0 : mem_q[rd_ptr_q];
    assign bus_if.o_count     = count_q;
    assign bus_if.o_overflow  = ovf_q;
    assign bus_if.o_underflow = udf_q;
endmodule
